// File: rtl/puf_meas_ctrl.sv
// puf_meas_ctrl: sequences one ring-oscillator measurement per response bit.
// For each bit it presents a challenge, clears the counters, opens the
// oscillator window, waits for the counters to settle, then compares counts.
// Collected bits leave as one word on a valid/ready handshake.
//
// Handshake: resp is transferred on a clock edge where resp_valid and
// resp_ready are both high. resp_valid stays high with resp stable until
// that edge and does not depend on resp_ready.
//
// Registered outputs (osc_en, cnt_clr, resp_valid) are computed from the
// current state and registered, so they trail the state register by one
// cycle. As a result, an accepted start at cycle 0 shows cnt_clr at cycle 1.
module puf_meas_ctrl #(
    parameter int CNT_W   = 8,
    parameter int CHAL_W  = 5,
    parameter int NBITS   = 8,
    parameter int WIN_CYC = 256,
    parameter int SETTLE  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CHAL_W-1:0] chal_base,
    input  logic [CNT_W-1:0]  cnt_a,
    input  logic [CNT_W-1:0]  cnt_b,
    output logic              osc_en,
    output logic              cnt_clr,
    output logic [CHAL_W-1:0] chal,
    output logic              busy,
    output logic [NBITS-1:0]  resp,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [3:0]        tie_cnt,
    output logic [2:0]        dbg_state
);

    localparam int PH_W  = $clog2(WIN_CYC + SETTLE + 2) + 1;
    localparam int IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_RUN    = 3'd2,
        S_SETTLE = 3'd3,
        S_SAMPLE = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [PH_W-1:0]   r_ph;
    logic [IDX_W-1:0]  r_idx;
    logic [CHAL_W-1:0] r_base;
    logic [CHAL_W-1:0] r_chal;
    logic [NBITS-1:0]  r_resp;
    logic [3:0]        r_tie;
    logic              r_osc_en;
    logic              r_cnt_clr;
    logic              r_resp_valid;
    logic              w_osc_en;
    logic              w_cnt_clr;
    logic              w_resp_valid;
    logic              w_last_bit;
    logic              w_accept;

    assign w_last_bit = (r_idx == IDX_W'(NBITS - 1));
    assign w_accept   = (r_state == S_IDLE) && start;

    // State register plus the per-state cycle counter (restarts on every state change).
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= S_IDLE;
            r_ph    <= '0;
        end else begin
            r_state <= w_next;
            r_ph    <= (w_next != r_state) ? '0 : r_ph + 1'b1;
        end
    end

    // Next-state selection; each timed state leaves on its last counted cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_CLEAR;
            S_CLEAR:  if (r_ph == PH_W'(1)) w_next = S_RUN;
            S_RUN:    if (r_ph == PH_W'(WIN_CYC - 1)) w_next = S_SETTLE;
            S_SETTLE: if (r_ph == PH_W'(SETTLE - 1)) w_next = S_SAMPLE;
            S_SAMPLE: w_next = w_last_bit ? S_DONE : S_CLEAR;
            S_DONE:   if (r_resp_valid && resp_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Output decode from the current state; valid drops right after the transfer edge.
    always_comb begin
        w_osc_en     = (r_state == S_RUN);
        w_cnt_clr    = (r_state == S_CLEAR);
        w_resp_valid = (r_state == S_DONE) && !(r_resp_valid && resp_ready);
    end

    // Output registers, challenge generation and response/tie collection.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_osc_en     <= 1'b0;
            r_cnt_clr    <= 1'b0;
            r_resp_valid <= 1'b0;
            r_idx        <= '0;
            r_base       <= '0;
            r_chal       <= '0;
            r_resp       <= '0;
            r_tie        <= '0;
        end else begin
            r_osc_en     <= w_osc_en;
            r_cnt_clr    <= w_cnt_clr;
            r_resp_valid <= w_resp_valid;
            if (w_accept) begin
                r_base <= chal_base;
                r_chal <= chal_base;
                r_idx  <= '0;
                r_resp <= '0;
                r_tie  <= '0;
            end else if (r_state == S_SAMPLE) begin
                r_resp[r_idx] <= (cnt_a > cnt_b);
                if ((cnt_a == cnt_b) && (r_tie != 4'hF)) begin
                    r_tie <= r_tie + 4'd1;
                end
                if (!w_last_bit) begin
                    r_idx  <= r_idx + 1'b1;
                    r_chal <= r_base + CHAL_W'(r_idx + 1'b1);
                end
            end
        end
    end

    assign osc_en     = r_osc_en;
    assign cnt_clr    = r_cnt_clr;
    assign resp_valid = r_resp_valid;
    assign chal       = r_chal;
    assign resp       = r_resp;
    assign tie_cnt    = r_tie;
    assign busy       = (r_state != S_IDLE);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_puf_meas_ctrl.sv
// Directed bench for puf_meas_ctrl: default-parameter instance plus a
// 20-bit short-window instance used for tie-count saturation.
module tb_puf_meas_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        start2;
    logic [4:0]  chal_base;
    logic [7:0]  cnt_a;
    logic [7:0]  cnt_b;
    logic        resp_ready;
    logic        osc_en, cnt_clr, busy, resp_valid;
    logic [4:0]  chal;
    logic [7:0]  resp;
    logic [3:0]  tie_cnt;
    logic [2:0]  dbg_state;
    logic        osc_en2, cnt_clr2, busy2, resp_valid2;
    logic [4:0]  chal2;
    logic [19:0] resp2;
    logic [3:0]  tie_cnt2;
    logic [2:0]  dbg_state2;

    int          nasrt = 0;
    int          nfail = 0;
    int          cnt_mode = 0;
    logic [4:0]  m_idx;
    logic [4:0]  chal_seq [8];
    int          osc_cnt [8];
    int          first_clr;
    int          valid_cyc;
    int          both_hi;

    always #5 clk = ~clk;

    puf_meas_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .chal_base(chal_base),
        .cnt_a(cnt_a), .cnt_b(cnt_b), .osc_en(osc_en), .cnt_clr(cnt_clr),
        .chal(chal), .busy(busy), .resp(resp), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .tie_cnt(tie_cnt), .dbg_state(dbg_state)
    );

    puf_meas_ctrl #(.NBITS(20), .WIN_CYC(4), .SETTLE(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .chal_base(chal_base),
        .cnt_a(cnt_a), .cnt_b(cnt_b), .osc_en(osc_en2), .cnt_clr(cnt_clr2),
        .chal(chal2), .busy(busy2), .resp(resp2), .resp_valid(resp_valid2),
        .resp_ready(resp_ready), .tie_cnt(tie_cnt2), .dbg_state(dbg_state2)
    );

    // Count sources: 0 = A always wins, 1 = A wins on even bit index only
    // (values chosen so a signed compare would give the opposite answer), 2 = tie.
    always_comb begin
        m_idx = chal - chal_base;
        cnt_a = 8'h90;
        cnt_b = 8'h40;
        if (cnt_mode == 1) begin
            if (m_idx[0]) begin
                cnt_a = 8'h21;
                cnt_b = 8'hC7;
            end else begin
                cnt_a = 8'hC7;
                cnt_b = 8'h21;
            end
        end else if (cnt_mode == 2) begin
            cnt_a = 8'h33;
            cnt_b = 8'h33;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nasrt++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start a run on the default instance (and optionally the 20-bit one) and
    // trace it until resp_valid or a cycle budget expires.
    task automatic do_run(input logic [4:0] base, input logic with2);
        int cyc;
        int bit_i;
        logic prev_clr;
        for (int i = 0; i < 8; i++) begin
            osc_cnt[i] = 0;
            chal_seq[i] = 5'h0;
        end
        @(negedge clk);
        chal_base = base;
        start = 1'b1;
        start2 = with2;
        @(negedge clk);
        start = 1'b0;
        start2 = 1'b0;
        cyc = 0;
        bit_i = -1;
        prev_clr = cnt_clr;
        first_clr = -1;
        valid_cyc = -1;
        both_hi = 0;
        while (cyc < 3000 && valid_cyc < 0) begin
            @(negedge clk);
            cyc++;
            if (cnt_clr && !prev_clr) begin
                bit_i++;
                if (first_clr < 0) first_clr = cyc;
                if (bit_i < 8) chal_seq[bit_i] = chal;
            end
            if (osc_en && bit_i >= 0 && bit_i < 8) osc_cnt[bit_i]++;
            if (osc_en && cnt_clr) both_hi++;
            prev_clr = cnt_clr;
            if (resp_valid) valid_cyc = cyc;
        end
    endtask

    task automatic check_run(input logic [4:0] base, input logic [7:0] exp_resp,
                             input logic [3:0] exp_tie);
        logic [4:0] e_chal;
        chk("valid_cycle", valid_cyc, 2105);
        chk("first_clr_cycle", first_clr, 1);
        chk("clr_osc_overlap", both_hi, 0);
        for (int i = 0; i < 8; i++) begin
            e_chal = base + 5'(i);
            chk($sformatf("chal_bit%0d", i), chal_seq[i], e_chal);
            chk($sformatf("osc_win_bit%0d", i), osc_cnt[i], 256);
        end
        chk("resp", resp, exp_resp);
        chk("tie_cnt", tie_cnt, exp_tie);
        chk("busy_done", busy, 1);
    endtask

    task automatic handshake();
        @(negedge clk);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("valid_after_hs", resp_valid, 0);
        chk("busy_after_hs", busy, 0);
    endtask

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        start2 = 1'b0;
        chal_base = 5'd0;
        resp_ready = 1'b0;

        // Reset held for three cycles.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_osc_en", osc_en, 0);
        chk("rst_cnt_clr", cnt_clr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", resp_valid, 0);
        chk("rst_resp", resp, 0);
        chk("rst_chal", chal, 0);
        chk("rst_tie", tie_cnt, 0);
        rst_n = 1'b0;

        // A always larger, chal 3..10.
        cnt_mode = 0;
        do_run(5'd3, 1'b0);
        check_run(5'd3, 8'hFF, 4'd0);

        // Backpressure: hold off for 10 cycles while poking start.
        chal_base = 5'd7;
        for (int i = 0; i < 10; i++) begin
            start = 1'b1;
            @(negedge clk);
            chk("bp_valid", resp_valid, 1);
            chk("bp_resp", resp, 8'hFF);
            chk("bp_busy", busy, 1);
        end
        // Transfer with start also high: start must be ignored.
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        start = 1'b0;
        chk("hs_valid_drop", resp_valid, 0);
        chk("hs_resp_held", resp, 8'hFF);
        chk("hs_idle", busy, 0);
        @(negedge clk);
        chk("hs_start_not_queued", busy, 0);

        // Alternating winner with wrapping challenge 30,31,0..5.
        cnt_mode = 1;
        do_run(5'd30, 1'b0);
        check_run(5'd30, 8'h55, 4'd0);
        handshake();

        // All ties; 20-bit instance saturates its tie count.
        cnt_mode = 2;
        do_run(5'd0, 1'b1);
        check_run(5'd0, 8'h00, 4'd8);
        chk("tie20_valid", resp_valid2, 1);
        chk("tie20_resp", resp2, 20'h0);
        chk("tie20_sat", tie_cnt2, 4'd15);
        handshake();
        chk("tie20_valid_after_hs", resp_valid2, 0);

        // Reset in the middle of the oscillator window, together with start.
        cnt_mode = 0;
        @(negedge clk);
        chal_base = 5'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        chk("mid_run_osc_on", osc_en, 1);
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        chk("mid_rst_osc_en", osc_en, 0);
        chk("mid_rst_cnt_clr", cnt_clr, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", resp_valid, 0);
        chk("mid_rst_chal", chal, 0);
        rst_n = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_beats_start", busy, 0);

        // Clean run after reset.
        do_run(5'd12, 1'b0);
        check_run(5'd12, 8'hFF, 4'd0);
        handshake();

        $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
        $finish;
    end

endmodule
